wb_port_arb: RTL and testbench
==============================

WB_PORT_ARB -- requirements
Module: wb_port_arb

Interface
REQ-001 Parameter STARVE_LIM, default 4, SHALL set the consecutive-loss limit for the secondary requester (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 p_vld  input  1  SHALL be the pipeline writeback request (the WB stage reg_wr output).
REQ-005 p_wa  input  3  SHALL be the pipeline destination register.
REQ-006 p_wd  input  16  SHALL be the pipeline write data.
REQ-007 p_stall  output  1  SHALL indicate that the pipeline write was not taken this cycle and the pipeline must hold.
REQ-008 s_vld  input  1  SHALL be the secondary (long-latency unit) write request.
REQ-009 s_wa  input  3  SHALL be the secondary destination register.
REQ-010 s_wd  input  16  SHALL be the secondary write data.
REQ-011 s_rdy  output  1  SHALL indicate the secondary buffer can accept an entry.
REQ-012 rf_we  output  1  SHALL be the registered register-file write enable.
REQ-013 rf_wa  output  3  SHALL be the registered register-file write address.
REQ-014 rf_wd  output  16  SHALL be the registered register-file write data.
REQ-015 pend_cnt  output  2  SHALL report the secondary buffer occupancy (0..2).

Function
REQ-016 The secondary path SHALL use a 2-entry FIFO; an entry is pushed when s_vld && s_rdy.
REQ-017 s_rdy SHALL equal (registered occupancy < 2); a same-cycle pop SHALL NOT raise s_rdy in that cycle.
REQ-018 Arbitration, each cycle: a forced FIFO grant (REQ-023) first, else p_vld -> pipeline, else FIFO non-empty -> FIFO head, else no grant.
REQ-019 The granted request SHALL appear on rf_we/rf_wa/rf_wd one cycle later (latency 1); no grant -> rf_we=0 and rf_wa/rf_wd hold their previous values.
REQ-020 Simultaneous push and pop SHALL be legal; occupancy is then unchanged and FIFO order is preserved.
REQ-021 A push into an empty FIFO SHALL NOT be grantable in the same cycle; the earliest grant is the next cycle.
REQ-022 The block SHALL NOT check address conflicts between requesters; write ordering is the upstream responsibility.
REQ-023 Starvation counter (4 bits, saturating at STARVE_LIM): increments each cycle the FIFO is non-empty and not granted, and clears on a FIFO grant or when the FIFO is empty; when it equals STARVE_LIM, the FIFO head SHALL be granted that cycle regardless of p_vld.
REQ-024 p_stall SHALL be 1 only in a cycle where p_vld=1 and the grant went to the FIFO (REQ-023); otherwise 0.
REQ-025 p_wa/p_wd SHALL be sampled only in cycles where the pipeline is granted.

Reset
REQ-026 While rst_n=0: rf_we=0, rf_wa=0, rf_wd=0, p_stall=0, s_rdy=0, pend_cnt=0, FIFO empty, starvation counter 0.
REQ-027 Assertion of rst_n mid-operation SHALL discard buffered entries immediately, with no further rf_we pulses.
REQ-028 s_rdy SHALL go to 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 With macro WB_STARVE_GUARD_EN defined, REQ-023 and REQ-024 SHALL apply.
REQ-030 Without WB_STARVE_GUARD_EN, the starvation counter SHALL be absent, the pipeline SHALL always win, and p_stall SHALL be constant 0.

Verification
REQ-031 Idle after reset, then p_vld=1, p_wa=3, p_wd=0x1234 for one cycle -> rf_we=1, rf_wa=3, rf_wd=0x1234 exactly one cycle later; pend_cnt=0.
REQ-032 p_vld=0; push s_wa=5/0xAAAA, then s_wa=6/0xBBBB on consecutive cycles -> rf writes 5/0xAAAA then 6/0xBBBB in order; s_rdy stays 1.
REQ-033 Hold p_vld=1 continuously; push 3 secondary entries back-to-back -> s_rdy=0 after the second push, pend_cnt=2, and the third entry is held by the source until s_rdy returns.
REQ-034 With the guard enabled and STARVE_LIM=4: p_vld=1 continuously and 1 FIFO entry -> after 4 pipeline grants, the FIFO is granted with p_stall=1 for exactly that cycle, then pipeline grants resume.
REQ-035 Same stimulus as REQ-034 without the guard -> the FIFO entry is never written while p_vld=1, and p_stall stays 0.
REQ-036 FIFO holding 2 entries, assert rst_n=0 for one cycle -> pend_cnt=0, no rf_we afterwards, and s_rdy=1 the cycle after release.

Source files
------------

// File: rtl/wb_port_arb.sv
// -----------------------------------------------------------------------------
// wb_port_arb -- single register-file write port shared by the pipeline
// writeback stage and a secondary (long-latency) requester.
//
// The pipeline write normally wins. Secondary writes are queued in a 2-entry
// FIFO and drain in cycles where the pipeline is not writing. The granted
// request is presented on the rf_* outputs one cycle later.
//
// Optional feature (macro WB_STARVE_GUARD_EN):
//   When defined, a saturating starvation counter forces a FIFO grant after
//   STARVE_LIM consecutive cycles in which a queued entry lost. In that cycle
//   o_p_stall tells the pipeline to hold its write. When undefined, the
//   pipeline always wins and o_p_stall is tied to 0.
//
// Parameters:
//   STARVE_LIM   consecutive-loss limit for the secondary requester (1..15)
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_p_vld      pipeline write request
//   i_p_wa/i_p_wd pipeline destination register / write data
//   o_p_stall    pipeline write not taken this cycle, pipeline must hold
//   i_s_vld      secondary write request
//   i_s_wa/i_s_wd secondary destination register / write data
//   o_s_rdy      secondary FIFO can accept an entry
//   o_rf_we      registered register-file write enable
//   o_rf_wa      registered register-file write address
//   o_rf_wd      registered register-file write data
//   o_pend_cnt   secondary FIFO occupancy (0..2)
// -----------------------------------------------------------------------------
module wb_port_arb #(
  parameter int STARVE_LIM = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p_vld,
  input  logic [2:0]  i_p_wa,
  input  logic [15:0] i_p_wd,
  output logic        o_p_stall,
  input  logic        i_s_vld,
  input  logic [2:0]  i_s_wa,
  input  logic [15:0] i_s_wd,
  output logic        o_s_rdy,
  output logic        o_rf_we,
  output logic [2:0]  o_rf_wa,
  output logic [15:0] o_rf_wd,
  output logic [1:0]  o_pend_cnt
);

  // Reject an out-of-range limit at elaboration time.
  if ((STARVE_LIM < 32'sd1) || (STARVE_LIM > 32'sd15)) begin : g_lim_check
    $error("wb_port_arb: STARVE_LIM must be in 1..15");
  end

  // Secondary FIFO storage and pointers
  logic [2:0]  r_fifo_wa [2];
  logic [15:0] r_fifo_wd [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_cnt;
  logic        r_s_rdy;

  // Registered write port
  logic        r_rf_we;
  logic [2:0]  r_rf_wa;
  logic [15:0] r_rf_wd;

  // Arbitration decode
  logic        w_fifo_ne;
  logic        w_push;
  logic        w_force;
  logic        w_grant_p;
  logic        w_grant_f;
  logic [1:0]  w_cnt_nxt;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIM4 = 4'(STARVE_LIM);
  logic [3:0]  r_starve;
`endif

  // Arbitration and FIFO occupancy decode. Grants look only at the registered
  // occupancy, so an entry pushed this cycle cannot be granted until the next.
  always_comb begin
    w_fifo_ne = (r_cnt != 2'd0);
    w_push    = i_s_vld && r_s_rdy;
`ifdef WB_STARVE_GUARD_EN
    w_force   = w_fifo_ne && (r_starve == LIM4);
`else
    w_force   = 1'b0;
`endif
    w_grant_p = 1'b0;
    w_grant_f = 1'b0;
    if (w_force) begin
      w_grant_f = 1'b1;
    end else if (i_p_vld) begin
      w_grant_p = 1'b1;
    end else if (w_fifo_ne) begin
      w_grant_f = 1'b1;
    end else begin
      w_grant_p = 1'b0;
      w_grant_f = 1'b0;
    end
    case ({w_push, w_grant_f})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // FIFO state, ready flag and the registered register-file write port.
  // Reset discards queued entries immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fifo_wa[0] <= 3'd0;
      r_fifo_wa[1] <= 3'd0;
      r_fifo_wd[0] <= 16'd0;
      r_fifo_wd[1] <= 16'd0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_cnt        <= 2'd0;
      r_s_rdy      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_wa      <= 3'd0;
      r_rf_wd      <= 16'd0;
    end else begin
      if (w_push) begin
        r_fifo_wa[r_wr_ptr] <= i_s_wa;
        r_fifo_wd[r_wr_ptr] <= i_s_wd;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_grant_f) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt   <= w_cnt_nxt;
      // Ready tracks the occupancy that will be registered, so a pop in the
      // same cycle as a full FIFO only raises ready on the following cycle.
      r_s_rdy <= (w_cnt_nxt != 2'd2);
      r_rf_we <= w_grant_p || w_grant_f;
      if (w_grant_p) begin
        r_rf_wa <= i_p_wa;
        r_rf_wd <= i_p_wd;
      end else if (w_grant_f) begin
        r_rf_wa <= r_fifo_wa[r_rd_ptr];
        r_rf_wd <= r_fifo_wd[r_rd_ptr];
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  // Counts consecutive cycles a queued entry lost; saturates at the limit,
  // which then forces the FIFO grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= 4'd0;
    end else if (!w_fifo_ne || w_grant_f) begin
      r_starve <= 4'd0;
    end else if (r_starve != LIM4) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  // Stall is only meaningful when the pipeline actually asked to write.
  assign o_p_stall  = w_force && i_p_vld;
  assign o_s_rdy    = r_s_rdy;
  assign o_rf_we    = r_rf_we;
  assign o_rf_wa    = r_rf_wa;
  assign o_rf_wd    = r_rf_wd;
  assign o_pend_cnt = r_cnt;

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb. Inputs change 1 time unit after a rising
// edge; outputs are inspected at that same point, when they reflect the grant
// decided at that edge.
module tb_wb_port_arb;

  logic        clk;
  logic        rst_n;
  logic        p_vld;
  logic [2:0]  p_wa;
  logic [15:0] p_wd;
  logic        p_stall;
  logic        s_vld;
  logic [2:0]  s_wa;
  logic [15:0] s_wd;
  logic        s_rdy;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;
  logic [1:0]  pend_cnt;

  int n_pass;
  int n_total;

  wb_port_arb #(.STARVE_LIM(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_p_vld    (p_vld),
    .i_p_wa     (p_wa),
    .i_p_wd     (p_wd),
    .o_p_stall  (p_stall),
    .i_s_vld    (s_vld),
    .i_s_wa     (s_wa),
    .i_s_wd     (s_wd),
    .o_s_rdy    (s_rdy),
    .o_rf_we    (rf_we),
    .o_rf_wa    (rf_wa),
    .o_rf_wd    (rf_wd),
    .o_pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p_vld = 1'b0; p_wa = 3'd0; p_wd = 16'd0;
    s_vld = 1'b0; s_wa = 3'd0; s_wd = 16'd0;
    tick(); tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL rst_we: got %0b exp 0", rf_we); else n_pass++;
    n_total++; if (rf_wa !== 3'd0) $display("FAIL rst_wa: got %0d exp 0", rf_wa); else n_pass++;
    n_total++; if (rf_wd !== 16'h0000) $display("FAIL rst_wd: got %h exp 0000", rf_wd); else n_pass++;
    n_total++; if (p_stall !== 1'b0) $display("FAIL rst_stall: got %0b exp 0", p_stall); else n_pass++;
    n_total++; if (s_rdy !== 1'b0) $display("FAIL rst_srdy: got %0b exp 0", s_rdy); else n_pass++;
    n_total++; if (pend_cnt !== 2'd0) $display("FAIL rst_pend: got %0d exp 0", pend_cnt); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++; if (s_rdy !== 1'b1) $display("FAIL rel_srdy: got %0b exp 1", s_rdy); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL rel_we: got %0b exp 0", rf_we); else n_pass++;
  endtask

  task automatic test_pipe_write();
    p_vld = 1'b1; p_wa = 3'd3; p_wd = 16'h1234;
    tick();
    p_vld = 1'b0; p_wa = 3'd0; p_wd = 16'h0000;
    n_total++; if (rf_we !== 1'b1) $display("FAIL pipe_we: got %0b exp 1", rf_we); else n_pass++;
    n_total++; if (rf_wa !== 3'd3) $display("FAIL pipe_wa: got %0d exp 3", rf_wa); else n_pass++;
    n_total++; if (rf_wd !== 16'h1234) $display("FAIL pipe_wd: got %h exp 1234", rf_wd); else n_pass++;
    n_total++; if (pend_cnt !== 2'd0) $display("FAIL pipe_pend: got %0d exp 0", pend_cnt); else n_pass++;
    tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL idle_we: got %0b exp 0", rf_we); else n_pass++;
    n_total++; if (rf_wa !== 3'd3) $display("FAIL hold_wa: got %0d exp 3", rf_wa); else n_pass++;
    n_total++; if (rf_wd !== 16'h1234) $display("FAIL hold_wd: got %h exp 1234", rf_wd); else n_pass++;
  endtask

  task automatic test_fifo_order();
    s_vld = 1'b1; s_wa = 3'd5; s_wd = 16'hAAAA;
    tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL ord_nosame: got %0b exp 0", rf_we); else n_pass++;
    n_total++; if (pend_cnt !== 2'd1) $display("FAIL ord_pend1: got %0d exp 1", pend_cnt); else n_pass++;
    n_total++; if (s_rdy !== 1'b1) $display("FAIL ord_rdy1: got %0b exp 1", s_rdy); else n_pass++;
    s_wa = 3'd6; s_wd = 16'hBBBB;
    tick();
    s_vld = 1'b0;
    n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd5, 16'hAAAA})
      $display("FAIL ord_first: got %0b/%0d/%h exp 1/5/aaaa", rf_we, rf_wa, rf_wd); else n_pass++;
    n_total++; if (pend_cnt !== 2'd1) $display("FAIL ord_pend2: got %0d exp 1", pend_cnt); else n_pass++;
    n_total++; if (s_rdy !== 1'b1) $display("FAIL ord_rdy2: got %0b exp 1", s_rdy); else n_pass++;
    tick();
    n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd6, 16'hBBBB})
      $display("FAIL ord_second: got %0b/%0d/%h exp 1/6/bbbb", rf_we, rf_wa, rf_wd); else n_pass++;
    n_total++; if (pend_cnt !== 2'd0) $display("FAIL ord_pend3: got %0d exp 0", pend_cnt); else n_pass++;
    tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL ord_drained: got %0b exp 0", rf_we); else n_pass++;
  endtask

  task automatic test_back_pressure();
    p_vld = 1'b1; p_wa = 3'd7; p_wd = 16'h1111;
    s_vld = 1'b1; s_wa = 3'd1; s_wd = 16'hC001;
    tick();
    s_wa = 3'd2; s_wd = 16'hC002;
    tick();
    s_wa = 3'd3; s_wd = 16'hC003;
    n_total++; if (s_rdy !== 1'b0) $display("FAIL bp_rdy_full: got %0b exp 0", s_rdy); else n_pass++;
    n_total++; if (pend_cnt !== 2'd2) $display("FAIL bp_pend_full: got %0d exp 2", pend_cnt); else n_pass++;
    tick();
    n_total++; if (pend_cnt !== 2'd2) $display("FAIL bp_pend_hold: got %0d exp 2", pend_cnt); else n_pass++;
    n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd7, 16'h1111})
      $display("FAIL bp_pipe: got %0b/%0d/%h exp 1/7/1111", rf_we, rf_wa, rf_wd); else n_pass++;
    p_vld = 1'b0;
    tick();
    n_total++; if ({rf_wa, rf_wd} !== {3'd1, 16'hC001})
      $display("FAIL bp_e1: got %0d/%h exp 1/c001", rf_wa, rf_wd); else n_pass++;
    n_total++; if (s_rdy !== 1'b1) $display("FAIL bp_rdy_back: got %0b exp 1", s_rdy); else n_pass++;
    tick();
    s_vld = 1'b0;
    n_total++; if ({rf_wa, rf_wd} !== {3'd2, 16'hC002})
      $display("FAIL bp_e2: got %0d/%h exp 2/c002", rf_wa, rf_wd); else n_pass++;
    n_total++; if (pend_cnt !== 2'd1) $display("FAIL bp_pend_pp: got %0d exp 1", pend_cnt); else n_pass++;
    tick();
    n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd3, 16'hC003})
      $display("FAIL bp_e3: got %0b/%0d/%h exp 1/3/c003", rf_we, rf_wa, rf_wd); else n_pass++;
    n_total++; if (pend_cnt !== 2'd0) $display("FAIL bp_pend_end: got %0d exp 0", pend_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    p_vld = 1'b1; p_wa = 3'd2; p_wd = 16'h2222;
    s_vld = 1'b1; s_wa = 3'd4; s_wd = 16'h4444;
    tick();
    s_vld = 1'b0;
    n_total++; if (p_stall !== 1'b0) $display("FAIL stv_stall0: got %0b exp 0", p_stall); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_total++; if (rf_wa !== 3'd2) $display("FAIL stv_pipe%0d: got %0d exp 2", i, rf_wa); else n_pass++;
      n_total++; if (p_stall !== 1'b0) $display("FAIL stv_nostall%0d: got %0b exp 0", i, p_stall); else n_pass++;
    end
    tick();
    n_total++; if (rf_wa !== 3'd2) $display("FAIL stv_pipe4: got %0d exp 2", rf_wa); else n_pass++;
`ifdef WB_STARVE_GUARD_EN
    n_total++; if (p_stall !== 1'b1) $display("FAIL stv_stall: got %0b exp 1", p_stall); else n_pass++;
    tick();
    n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd4, 16'h4444})
      $display("FAIL stv_forced: got %0b/%0d/%h exp 1/4/4444", rf_we, rf_wa, rf_wd); else n_pass++;
    n_total++; if (p_stall !== 1'b0) $display("FAIL stv_stall_end: got %0b exp 0", p_stall); else n_pass++;
    n_total++; if (pend_cnt !== 2'd0) $display("FAIL stv_pend: got %0d exp 0", pend_cnt); else n_pass++;
    tick();
    n_total++; if ({rf_we, rf_wa} !== {1'b1, 3'd2})
      $display("FAIL stv_resume: got %0b/%0d exp 1/2", rf_we, rf_wa); else n_pass++;
`else
    for (int i = 0; i < 4; i++) begin
      n_total++; if (p_stall !== 1'b0) $display("FAIL stv_nog_stall%0d: got %0b exp 0", i, p_stall); else n_pass++;
      tick();
      n_total++; if (rf_wa !== 3'd2) $display("FAIL stv_nog_pipe%0d: got %0d exp 2", i, rf_wa); else n_pass++;
      n_total++; if (pend_cnt !== 2'd1) $display("FAIL stv_nog_pend%0d: got %0d exp 1", i, pend_cnt); else n_pass++;
    end
    p_vld = 1'b0;
    tick();
    n_total++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd4, 16'h4444})
      $display("FAIL stv_nog_drain: got %0b/%0d/%h exp 1/4/4444", rf_we, rf_wa, rf_wd); else n_pass++;
`endif
    p_vld = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    p_vld = 1'b1; p_wa = 3'd0; p_wd = 16'h0F0F;
    s_vld = 1'b1; s_wa = 3'd5; s_wd = 16'h5555;
    tick();
    s_wa = 3'd6; s_wd = 16'h6666;
    tick();
    n_total++; if (pend_cnt !== 2'd2) $display("FAIL mid_full: got %0d exp 2", pend_cnt); else n_pass++;
    p_vld = 1'b0; s_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (pend_cnt !== 2'd0) $display("FAIL mid_pend: got %0d exp 0", pend_cnt); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL mid_we: got %0b exp 0", rf_we); else n_pass++;
    n_total++; if (s_rdy !== 1'b0) $display("FAIL mid_srdy: got %0b exp 0", s_rdy); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (rf_we !== 1'b0) $display("FAIL mid_nowe%0d: got %0b exp 0", i, rf_we); else n_pass++;
      n_total++; if (pend_cnt !== 2'd0) $display("FAIL mid_pend%0d: got %0d exp 0", i, pend_cnt); else n_pass++;
    end
    n_total++; if (s_rdy !== 1'b1) $display("FAIL mid_rel_srdy: got %0b exp 1", s_rdy); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_pipe_write();
    test_fifo_order();
    test_back_pressure();
    test_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
